// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and access-decode helpers
// shared by lsu_mem_stage and load_extract.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, STORE, LOAD, WAIT, RESP, ERR} lsu_state_t;

  // Byte-lane enables for a store of the given size at the given lane offset.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << addr_lo;
      F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Flags any access that cannot be performed: misaligned halves/words and
  // funct3 encodings that are not a valid load (or store, when is_store).
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                      input logic is_store);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = |addr_lo;
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_extract.sv
// load_extract: selects the addressed byte/half of a raw memory word and
// sign- or zero-extends it according to the load funct3.
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = raw_i[7:0];
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: sequences MEM-stage loads/stores onto a word-wide data
// memory, aligns load data and stalls upstream while an access is in flight.
// Optional macro LSU_PERF_EN adds saturating 16-bit load/store/error counters.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  req_ready,
  output logic                  stall,
  output logic [DM_ADDRESS-3:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  access_err
`ifdef LSU_PERF_EN
  ,
  output logic [15:0]           load_cnt,
  output logic [15:0]           store_cnt,
  output logic [15:0]           err_cnt
`endif
);

  lsu_state_t            state_q, state_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic                  store_q, store_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]     resp_data_q, resp_data_d;
  logic [DATA_W-1:0]     ext_data;

  logic req_any, illegal, accept;

  assign req_any = req_valid & (req_read | req_write);
  assign illegal = (req_read & req_write) | misaligned(req_funct3, req_addr[1:0], req_write);
  assign accept  = (state_q == IDLE) & req_any;

  load_extract u_extract (
    .raw_i    (mem_rdata),
    .addr_lo_i(addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      store_q     <= 1'b0;
      cnt_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      store_q     <= store_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = illegal ? ERR : (req_write ? STORE : LOAD);
      STORE:   state_d = IDLE;
      LOAD:    state_d = WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, latency countdown and load-result capture
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    store_d     = store_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      f3_d    = req_funct3;
      store_d = req_write;
      // A rejected load still completes with a zero result.
      if (illegal && !req_write) resp_data_d = '0;
    end
    if (state_q == LOAD) begin
      cnt_d = 2'(MEM_LAT - 1);
    end else if (state_q == WAIT) begin
      if (cnt_q == 2'd0) resp_data_d = ext_data;
      else               cnt_d = cnt_q - 2'd1;
    end
  end

  // Outputs decoded from the current state and the captured request
  always_comb begin
    req_ready  = (state_q == IDLE);
    stall      = (state_q != IDLE) | (req_any & ~req_ready);
    mem_re     = (state_q == LOAD);
    mem_we     = (state_q == STORE);
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    if (state_q == STORE) begin
      mem_be = store_be(f3_q, addr_q[1:0]);
      case (f3_q)
        F3_B:    mem_wdata = {4{wdata_q[7:0]}};
        F3_H:    mem_wdata = {2{wdata_q[15:0]}};
        default: mem_wdata = wdata_q;
      endcase
    end
    resp_valid = (state_q == RESP) | ((state_q == ERR) & ~store_q);
    access_err = (state_q == ERR);
  end

  assign mem_addr  = addr_q[DM_ADDRESS-1:2];
  assign resp_data = resp_data_q;

`ifdef LSU_PERF_EN
  logic [15:0] load_cnt_q, store_cnt_q, err_cnt_q;

  // Saturating completion counters
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (state_q == RESP  && load_cnt_q  != 16'hFFFF) load_cnt_q  <= load_cnt_q + 16'd1;
      if (state_q == STORE && store_cnt_q != 16'hFFFF) store_cnt_q <= store_cnt_q + 16'd1;
      if (state_q == ERR   && err_cnt_q   != 16'hFFFF) err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: scoreboard bench. Instance A (MEM_LAT=1) runs directed
// loads/stores/errors against a byte-enabled memory model; instance B
// (MEM_LAT=3) checks stall length for a load followed by a store.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  localparam int K_ST = 0, K_LD = 1, K_ELD = 2, K_EST = 3, K_EANY = 4;

  typedef struct {
    int          id;
    int          kind;
    logic [6:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic        a_req_valid = 0, a_req_read = 0, a_req_write = 0;
  logic [8:0]  a_req_addr = 0;
  logic [31:0] a_req_wdata = 0;
  logic [2:0]  a_req_funct3 = 0;
  logic        a_req_ready, a_stall, a_mem_re, a_mem_we, a_resp_valid, a_access_err;
  logic [6:0]  a_mem_addr;
  logic [3:0]  a_mem_be;
  logic [31:0] a_mem_wdata, a_mem_rdata, a_resp_data;
  // ---------------- instance B ----------------
  logic        b_req_valid = 0, b_req_read = 0, b_req_write = 0;
  logic [8:0]  b_req_addr = 0;
  logic [31:0] b_req_wdata = 0;
  logic [2:0]  b_req_funct3 = 0;
  logic        b_req_ready, b_stall, b_mem_re, b_mem_we, b_resp_valid, b_access_err;
  logic [6:0]  b_mem_addr;
  logic [3:0]  b_mem_be;
  logic [31:0] b_mem_wdata, b_mem_rdata, b_resp_data;
`ifdef LSU_PERF_EN
  logic [15:0] a_load_cnt, a_store_cnt, a_err_cnt, b_load_cnt, b_store_cnt, b_err_cnt;
`endif

  lsu_mem_stage #(.DM_ADDRESS(9), .DATA_W(32), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_read(a_req_read), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_funct3(a_req_funct3),
    .req_ready(a_req_ready), .stall(a_stall),
    .mem_addr(a_mem_addr), .mem_re(a_mem_re), .mem_we(a_mem_we), .mem_be(a_mem_be),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .resp_valid(a_resp_valid), .resp_data(a_resp_data), .access_err(a_access_err)
`ifdef LSU_PERF_EN
    ,
    .load_cnt(a_load_cnt), .store_cnt(a_store_cnt), .err_cnt(a_err_cnt)
`endif
  );

  lsu_mem_stage #(.DM_ADDRESS(9), .DATA_W(32), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_read(b_req_read), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_funct3(b_req_funct3),
    .req_ready(b_req_ready), .stall(b_stall),
    .mem_addr(b_mem_addr), .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .access_err(b_access_err)
`ifdef LSU_PERF_EN
    ,
    .load_cnt(b_load_cnt), .store_cnt(b_store_cnt), .err_cnt(b_err_cnt)
`endif
  );

  // Memory model A: 1-cycle read latency, byte-enabled writes
  logic [31:0] mem_a [128];
  logic [6:0]  a_ad1;
  always @(posedge clk) begin
    a_ad1 <= a_mem_addr;
    if (reset) begin
      for (int i = 0; i < 128; i++) mem_a[i] <= 32'h0;
      mem_a[2] <= 32'h80FF7F01;
      mem_a[3] <= 32'h11223344;
    end else if (a_mem_we) begin
      for (int i = 0; i < 4; i++)
        if (a_mem_be[i]) mem_a[a_mem_addr][8*i +: 8] <= a_mem_wdata[8*i +: 8];
    end
  end
  assign a_mem_rdata = mem_a[a_ad1];

  // Memory model B: 3-cycle read latency, word 2 holds a known pattern
  logic [6:0] b_ad1, b_ad2, b_ad3;
  always @(posedge clk) begin
    b_ad1 <= b_mem_addr;
    b_ad2 <= b_ad1;
    b_ad3 <= b_ad2;
  end
  assign b_mem_rdata = (b_ad3 == 7'd2) ? 32'h80FF7F01 : 32'h0;

  // ---------------- scoreboard ----------------
  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0;
  int   n_ld = 0, n_st = 0, n_err = 0, n_re_seen = 0;

  task automatic chk(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL txn %0d %s: got %h expected %h", id, what, act, exp);
  endtask

  task automatic issue(input int id, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [8:0] addr, input logic [31:0] wd, input int kind,
                       input logic [3:0] be, input logic [31:0] data);
    exp_t e;
    int   guard;
    a_req_valid = 1'b1; a_req_read = rd; a_req_write = wr;
    a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd;
    guard = 0;
    while (!a_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!a_req_ready) begin
      n_chk++;
      $display("FAIL txn %0d accept: req_ready still 0 after %0d cycles", id, guard);
    end
    e.id = id; e.kind = kind; e.addr = addr[8:2]; e.be = be; e.data = data; e.acc = cyc + 1;
    sbq.push_back(e);
    case (kind)
      K_LD:    n_ld++;
      K_ST:    n_st++;
      default: n_err++;
    endcase
    @(negedge clk);
    a_req_valid = 1'b0; a_req_read = 1'b0; a_req_write = 1'b0;
  endtask

  // Monitor: pops an expectation whenever instance A presents a strobe or completion
  exp_t cur;
  int   lat;
  always @(negedge clk) begin
    if (a_mem_re) n_re_seen++;
    if (!reset && (a_mem_we || a_resp_valid || a_access_err)) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_event: we=%b rv=%b err=%b with no pending transaction",
                 a_mem_we, a_resp_valid, a_access_err);
      end else begin
        cur = sbq.pop_front();
        lat = cyc - cur.acc + 1;
        $display("txn %0d: kind=%0d we=%b be=%b waddr=%h wdata=%h rv=%b err=%b rdata=%h lat=%0d",
                 cur.id, cur.kind, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata,
                 a_resp_valid, a_access_err, a_resp_data, lat);
        case (cur.kind)
          K_ST: begin
            chk(cur.id, "st_we", a_mem_we, 1);
            chk(cur.id, "st_be", a_mem_be, cur.be);
            chk(cur.id, "st_wdata", a_mem_wdata, cur.data);
            chk(cur.id, "st_addr", a_mem_addr, cur.addr);
            chk(cur.id, "st_noresp", {a_resp_valid, a_access_err}, 0);
            chk(cur.id, "st_lat", lat, 1);
          end
          K_LD: begin
            chk(cur.id, "ld_valid", {a_resp_valid, a_access_err}, 2);
            chk(cur.id, "ld_data", a_resp_data, cur.data);
            chk(cur.id, "ld_lat", lat, 3);
          end
          K_ELD: begin
            chk(cur.id, "eld_flags", {a_access_err, a_resp_valid, a_mem_we}, 6);
            chk(cur.id, "eld_data", a_resp_data, 0);
            chk(cur.id, "eld_lat", lat, 1);
          end
          K_EST: begin
            chk(cur.id, "est_flags", {a_access_err, a_resp_valid, a_mem_we}, 4);
            chk(cur.id, "est_lat", lat, 1);
          end
          default: begin
            chk(cur.id, "eany_flags", {a_access_err, a_mem_we}, 2);
            chk(cur.id, "eany_lat", lat, 1);
          end
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard, nst, bad_ready, saw_resp;
    logic [31:0] got;
    logic [6:0]  rv_seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk(0, "rst_ready_stall", {a_req_ready, a_stall}, 2);
    chk(0, "rst_strobes", {a_mem_re, a_mem_we, a_mem_be}, 0);
    chk(0, "rst_wdata", a_mem_wdata, 0);
    chk(0, "rst_maddr", a_mem_addr, 0);
    chk(0, "rst_resp", {a_resp_valid, a_access_err}, 0);
    chk(0, "rst_rdata", a_resp_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back-to-back
    issue( 1, 0, 1, F3_B,  9'h007, 32'h000000A5, K_ST,  4'b1000, 32'hA5A5A5A5);
    issue( 2, 1, 0, F3_B,  9'h00B, 32'h0,        K_LD,  4'b0000, 32'hFFFFFF80);
    issue( 3, 1, 0, F3_BU, 9'h00B, 32'h0,        K_LD,  4'b0000, 32'h00000080);
    issue( 4, 1, 0, F3_H,  9'h00A, 32'h0,        K_LD,  4'b0000, 32'hFFFF80FF);
    issue( 5, 1, 0, F3_W,  9'h008, 32'h0,        K_LD,  4'b0000, 32'h80FF7F01);
    issue( 6, 1, 0, F3_HU, 9'h008, 32'h0,        K_LD,  4'b0000, 32'h00007F01);
    issue( 7, 1, 0, F3_B,  9'h008, 32'h0,        K_LD,  4'b0000, 32'h00000001);
    issue( 8, 1, 0, F3_W,  9'h006, 32'h0,        K_ELD, 4'b0000, 32'h0);
    issue( 9, 0, 1, F3_H,  9'h003, 32'h12345678, K_EST, 4'b0000, 32'h0);
    issue(10, 0, 1, F3_H,  9'h00E, 32'h1234BEEF, K_ST,  4'b1100, 32'hBEEFBEEF);
    issue(11, 1, 0, F3_W,  9'h00C, 32'h0,        K_LD,  4'b0000, 32'hBEEF3344);
    issue(12, 0, 1, F3_W,  9'h010, 32'hDEADBEEF, K_ST,  4'b1111, 32'hDEADBEEF);
    issue(13, 1, 0, F3_W,  9'h010, 32'h0,        K_LD,  4'b0000, 32'hDEADBEEF);
    issue(14, 1, 0, F3_W,  9'h004, 32'h0,        K_LD,  4'b0000, 32'hA5000000);
    issue(15, 1, 0, 3'b011, 9'h000, 32'h0,       K_ELD, 4'b0000, 32'h0);
    issue(16, 0, 1, 3'b100, 9'h000, 32'h0,       K_EST, 4'b0000, 32'h0);
    issue(17, 1, 1, F3_W,  9'h010, 32'h0,        K_EANY, 4'b0000, 32'h0);
    issue(18, 1, 0, F3_H,  9'h005, 32'h0,        K_ELD, 4'b0000, 32'h0);
    issue(19, 0, 1, F3_B,  9'h00D, 32'h00000077, K_ST,  4'b0010, 32'h77777777);
    issue(20, 1, 0, F3_BU, 9'h00D, 32'h0,        K_LD,  4'b0000, 32'h00000077);
    issue(21, 1, 0, F3_HU, 9'h00E, 32'h0,        K_LD,  4'b0000, 32'h0000BEEF);
    issue(22, 1, 0, F3_H,  9'h00E, 32'h0,        K_LD,  4'b0000, 32'hFFFFBEEF);

    guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    chk(0, "sb_drained", sbq.size(), 0);
    chk(0, "mem_re_count", n_re_seen, n_ld);
`ifdef LSU_PERF_EN
    chk(0, "perf_load_cnt", a_load_cnt, n_ld);
    chk(0, "perf_store_cnt", a_store_cnt, n_st);
    chk(0, "perf_err_cnt", a_err_cnt, n_err);
`endif

    // MEM_LAT=3: LW then an immediately presented SW
    b_req_valid = 1'b1; b_req_read = 1'b1; b_req_write = 1'b0;
    b_req_funct3 = F3_W; b_req_addr = 9'h008;
    @(negedge clk);
    b_req_read = 1'b0; b_req_write = 1'b1; b_req_addr = 9'h00C; b_req_wdata = 32'hCAFEF00D;
    nst = 0; bad_ready = 0; saw_resp = 0; got = 32'h0;
    while (b_stall && nst < 20) begin
      if (b_req_ready) bad_ready++;
      if (b_resp_valid) begin
        saw_resp = 1;
        got = b_resp_data;
      end
      nst++;
      @(negedge clk);
    end
    $display("txn 30: lat3 LW stall_cycles=%0d resp=%0d data=%h", nst, saw_resp, got);
    chk(30, "lat3_stall_cycles", nst, 5);
    chk(30, "lat3_ready_low", bad_ready, 0);
    chk(30, "lat3_resp_seen", saw_resp, 1);
    chk(30, "lat3_resp_data", got, 32'h80FF7F01);
    chk(30, "lat3_ready_after", b_req_ready, 1);
    @(negedge clk);
    b_req_valid = 1'b0; b_req_write = 1'b0;
    $display("txn 31: lat3 SW we=%b be=%b addr=%h wdata=%h", b_mem_we, b_mem_be, b_mem_addr, b_mem_wdata);
    chk(31, "lat3_sw_we_be", {b_mem_we, b_mem_be}, 5'b11111);
    chk(31, "lat3_sw_wdata", b_mem_wdata, 32'hCAFEF00D);
    chk(31, "lat3_sw_addr", b_mem_addr, 7'h03);

    // Reset during WAIT aborts the load on instance A
    a_req_valid = 1'b1; a_req_read = 1'b1; a_req_funct3 = F3_W; a_req_addr = 9'h008;
    @(negedge clk);
    a_req_valid = 1'b0; a_req_read = 1'b0;
    chk(40, "abort_mem_re", a_mem_re, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    $display("txn 40: reset in WAIT ready=%b rv=%b rdata=%h", a_req_ready, a_resp_valid, a_resp_data);
    chk(40, "abort_idle", {a_req_ready, a_stall, a_mem_re}, 3'b100);
    chk(40, "abort_noresp", {a_resp_valid, a_access_err}, 0);
    chk(40, "abort_rdata", a_resp_data, 0);
    reset = 1'b0;
    rv_seen = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rv_seen[i] = a_resp_valid | a_mem_re | a_mem_we;
    end
    chk(40, "abort_quiet", rv_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
